// File: rtl/fifo_rd_packer_if.sv
// Handshake bundle between the byte FIFO read port, the packer and the word consumer.
// master = packer side, slave = FIFO/consumer side.
interface fifo_rd_packer_if #(
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = 16
);
    logic                      fifo_empty;
    logic [7:0]                fifo_buf_out;
    logic                      fifo_rd_en;
    logic                      flush;
    logic [8*WORD_BYTES-1:0]   out_data;
    logic [2:0]                out_bytes;
    logic                      out_valid;
    logic                      out_ready;
    logic [CNT_W-1:0]          word_count;

    modport master (
        input  fifo_empty, fifo_buf_out, flush, out_ready,
        output fifo_rd_en, out_data, out_bytes, out_valid, word_count
    );

    modport slave (
        output fifo_empty, fifo_buf_out, flush, out_ready,
        input  fifo_rd_en, out_data, out_bytes, out_valid, word_count
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the read side of the byte FIFO and packs them little-endian into
// WORD_BYTES-wide words on a valid/ready handshake; flush emits a zero-padded partial word.
module fifo_rd_packer #(
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_r,
    input  logic                  rst,
    fifo_rd_packer_if.master      bus
);
    localparam int DW = 8 * WORD_BYTES;
    localparam logic [2:0] WB = 3'(WORD_BYTES);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_fill;
    logic              r_pend;
    logic              r_flush_req;
    logic [DW-1:0]     r_shift;
    logic [2:0]        r_bytes;
    logic              r_valid;
    logic [CNT_W-1:0]  r_count;

    logic [2:0]        w_fill_cap;
    logic [DW-1:0]     w_shift_cap;
    logic              w_rd_en;

    function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] word,
                                               input logic [2:0]    lane,
                                               input logic [7:0]    b);
        logic [DW-1:0] res;
        res = word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane == 3'(i)) res[8*i +: 8] = b;
        end
        return res;
    endfunction

    // Fill count and shift register as they stand once the in-flight byte (if any) lands.
    assign w_fill_cap  = r_fill + {2'b00, r_pend};
    assign w_shift_cap = r_pend ? put_byte(r_shift, r_fill, bus.fifo_buf_out) : r_shift;

    assign w_rd_en = !rst && (r_state == S_FILL) && !bus.fifo_empty &&
                     (w_fill_cap < WB) && !r_flush_req && !bus.flush;

    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_fill      <= 3'd0;
            r_pend      <= 1'b0;
            r_flush_req <= 1'b0;
            r_shift     <= '0;
            r_bytes     <= 3'd0;
            r_valid     <= 1'b0;
            r_count     <= '0;
        end else begin
            r_pend <= w_rd_en;
            case (r_state)
                S_FILL: begin
                    r_shift <= w_shift_cap;
                    r_fill  <= w_fill_cap;
                    // A flush landing with the word-completing byte is absorbed by the full word.
                    if (r_pend && (w_fill_cap == WB)) begin
                        r_valid <= 1'b1;
                        r_bytes <= WB;
                        r_state <= S_HOLD;
                    end else if (bus.flush) begin
                        if (r_pend) begin
                            r_flush_req <= 1'b1;
                            r_state     <= S_DRAIN;
                        end else if (r_fill != 3'd0) begin
                            r_flush_req <= 1'b1;
                            r_valid     <= 1'b1;
                            r_bytes     <= r_fill;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_DRAIN: begin
                    r_shift <= w_shift_cap;
                    r_fill  <= w_fill_cap;
                    if (w_fill_cap != 3'd0) begin
                        r_valid <= 1'b1;
                        r_bytes <= w_fill_cap;
                        r_state <= S_HOLD;
                    end else begin
                        r_flush_req <= 1'b0;
                        r_state     <= S_FILL;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_valid     <= 1'b0;
                        r_fill      <= 3'd0;
                        r_shift     <= '0;
                        r_bytes     <= 3'd0;
                        r_flush_req <= 1'b0;
                        r_count     <= r_count + 1'b1;
                        r_state     <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_data   = r_shift;
    assign bus.out_bytes  = r_bytes;
    assign bus.out_valid  = r_valid;
    assign bus.word_count = r_count;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a small pointer FIFO model feeds the packer and
// each step checks outputs against hand-computed values with immediate assertions.
module tb_fifo_rd_packer;
    localparam int WB = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.WORD_BYTES(WB), .CNT_W(CW)) bus ();

    fifo_rd_packer #(.WORD_BYTES(WB), .CNT_W(CW)) dut (
        .clk_r (clk),
        .rst   (rst),
        .bus   (bus.master)
    );

    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int vectors = 0;
    int miscompares = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_buf_out <= mem[rd_ptr[5:0]];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr++;
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_valid_seen"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        wr_ptr = rd_ptr;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [1:0] exp_cnt [5];
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held with a non-empty FIFO
        @(negedge clk);
        push(8'hAA);
        push(8'hBB);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
            check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_count", {30'd0, bus.word_count}, 32'd0);
        end
        check("rst_data", bus.out_data, 32'd0);
        check("rst_bytes", {29'd0, bus.out_bytes}, 32'd0);
        wr_ptr = rd_ptr;
        rst = 1'b0;

        // Full word, downstream always ready
        bus.out_ready = 1'b1;
        s = rd_ptr;
        push(8'd12); push(8'd24); push(8'd2); push(8'd4);
        wait_valid("full");
        check("full_data", bus.out_data, 32'h0402180C);
        check("full_bytes", {29'd0, bus.out_bytes}, 32'd4);
        @(negedge clk);
        check("full_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        check("full_count", {30'd0, bus.word_count}, 32'd1);
        check("full_pops", rd_ptr - s, 32'd4);

        // Back-pressure: first word held, no further pops while stalled
        do_reset();
        bus.out_ready = 1'b0;
        s = rd_ptr;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_valid("bp1");
        check("bp1_data", bus.out_data, 32'h04030201);
        repeat (10) @(negedge clk);
        check("bp_hold_data", bus.out_data, 32'h04030201);
        check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_hold_pops", rd_ptr - s, 32'd4);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp1_count", {30'd0, bus.word_count}, 32'd1);
        check("bp1_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        wait_valid("bp2");
        check("bp2_data", bus.out_data, 32'h08070605);
        @(negedge clk);
        check("bp2_count", {30'd0, bus.word_count}, 32'd2);
        check("bp2_pops", rd_ptr - s, 32'd8);

        // Partial flush while the single byte is in flight (DRAIN path)
        do_reset();
        bus.out_ready = 1'b0;
        push(8'h00);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("drain_valid_wait", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("drain_valid", {31'd0, bus.out_valid}, 32'd1);
        check("drain_data", bus.out_data, 32'h00000000);
        check("drain_bytes", {29'd0, bus.out_bytes}, 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("drain_count", {30'd0, bus.word_count}, 32'd1);

        // Partial flush with two bytes already captured: zero-padded upper lanes
        do_reset();
        bus.out_ready = 1'b0;
        push(8'h55); push(8'h66);
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("part_valid", {31'd0, bus.out_valid}, 32'd1);
        check("part_data", bus.out_data, 32'h00006655);
        check("part_bytes", {29'd0, bus.out_bytes}, 32'd2);

        // Idle flush emits nothing and the packer keeps filling normally
        do_reset();
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
        check("idle_count", {30'd0, bus.word_count}, 32'd0);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_valid("idle_next");
        check("idle_next_data", bus.out_data, 32'h44332211);
        check("idle_next_bytes", {29'd0, bus.out_bytes}, 32'd4);

        // Flush coinciding with the word-completing capture: one full word only
        do_reset();
        bus.out_ready = 1'b0;
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("coinc_valid", {31'd0, bus.out_valid}, 32'd1);
        check("coinc_data", bus.out_data, 32'hA3A2A1A0);
        check("coinc_bytes", {29'd0, bus.out_bytes}, 32'd4);
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("coinc_no_extra", {31'd0, bus.out_valid}, 32'd0);
        check("coinc_count", {30'd0, bus.word_count}, 32'd1);

        // Counter wrap with a 2-bit word counter
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push(8'(i));
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
        for (int k = 0; k < 5; k++) begin
            wait_valid("wrap");
            @(negedge clk);
            check("wrap_count", {30'd0, bus.word_count}, {30'd0, exp_cnt[k]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
